// File: rtl/mips_trace_pkg.sv
// Shared types for the MIPS retirement-trace buffer.
// Capture modes, FSM states and the trace entry layout.
package mips_trace_pkg;

  localparam logic MODE_FILL = 1'b0;
  localparam logic MODE_TRIG = 1'b1;

  localparam int TRACE_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    POST,
    DONE
  } state_t;

  typedef struct packed {
    logic [TRACE_W-1:0] pc;
    logic [TRACE_W-1:0] instr;
    logic               wrEn;
    logic [4:0]         wrReg;
    logic [TRACE_W-1:0] wrData;
  } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// Trace entry storage: flop array, one synchronous write port,
// one asynchronous read port, contents not reset.
module trace_ram #(
  parameter  int DEPTH = 16,
  parameter  int W     = 102,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wAddr,
  input  logic [W-1:0]  wData,
  input  logic [AW-1:0] rAddr,
  output logic [W-1:0]  rData
);

  logic [W-1:0] mem [DEPTH];

  // Store one entry per enabled cycle.
  always_ff @(posedge clk) begin
    if (we) mem[wAddr] <= wData;
  end

  assign rData = mem[rAddr];

endmodule

// File: rtl/mips_trace_buffer.sv
// Retirement-trace capture buffer: FILL or ring/PC-trigger capture,
// then oldest-first drain over a valid/ready port.
module mips_trace_buffer
  import mips_trace_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_mode,
  input  logic [DATA_W-1:0]        cfg_trig_pc,
  input  logic                     arm,
  input  logic                     commit_valid,
  input  logic [DATA_W-1:0]        commit_pc,
  input  logic [DATA_W-1:0]        commit_instr,
  input  logic                     commit_wr_en,
  input  logic [4:0]               commit_wr_reg,
  input  logic [DATA_W-1:0]        commit_wr_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_pc,
  output logic [DATA_W-1:0]        out_instr,
  output logic                     out_wr_en,
  output logic [4:0]               out_wr_reg,
  output logic [DATA_W-1:0]        out_wr_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     triggered,
  output logic                     overflow,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 3 * DATA_W + 6;

  state_t state, nextState;

  logic          mode;
  logic [AW-1:0] wrPtr, rdPtr, postLeft;
  logic [CW-1:0] cnt;
  logic          full, hit, store, pop;
  logic [EW-1:0] wEntry, rEntry;

  assign full  = cnt == CW'(DEPTH);
  assign hit   = commit_pc == cfg_trig_pc;
  assign store = commit_valid && !arm &&
                 (state == CAPTURE || state == POST);
  assign out_valid = state == DONE && cnt != '0;
  assign pop   = out_valid && out_ready && !arm;

  assign wEntry = {commit_pc, commit_instr, commit_wr_en,
                   commit_wr_reg, commit_wr_data};
  assign {out_pc, out_instr, out_wr_en,
          out_wr_reg, out_wr_data} = rEntry;

  assign count = cnt;
  assign done  = state == DONE;

  trace_ram #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) uRam (
    .clk   (clk),
    .we    (store),
    .wAddr (wrPtr),
    .wData (wEntry),
    .rAddr (rdPtr),
    .rData (rEntry)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state decode; arm restarts capture from any state.
  always_comb begin
    nextState = state;
    if (arm) begin
      nextState = CAPTURE;
    end else begin
      unique case (state)
        IDLE: nextState = IDLE;
        CAPTURE: begin
          if (commit_valid) begin
            if (mode == MODE_FILL) begin
              if (cnt == CW'(DEPTH - 1)) nextState = DONE;
            end else if (hit) begin
              nextState = (POST_TRIG == 0) ? DONE : POST;
            end
          end
        end
        POST: begin
          if (commit_valid && postLeft == AW'(1))
            nextState = DONE;
        end
        DONE: begin
          if (pop && cnt == CW'(1)) nextState = IDLE;
        end
        default: nextState = IDLE;
      endcase
    end
  end

  // Pointers, occupancy, post-trigger budget and sticky flags.
  always_ff @(posedge clk) begin
    if (reset || arm) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      cnt       <= '0;
      postLeft  <= '0;
      triggered <= 1'b0;
      overflow  <= 1'b0;
      mode      <= reset ? MODE_FILL : cfg_mode;
    end else begin
      if (store) begin
        wrPtr <= wrPtr + AW'(1);
        if (mode == MODE_TRIG && full) begin
          rdPtr    <= rdPtr + AW'(1);
          overflow <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
        if (state == CAPTURE && mode == MODE_TRIG && hit) begin
          triggered <= 1'b1;
          postLeft  <= AW'(POST_TRIG);
        end
        if (state == POST) postLeft <= postLeft - AW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + AW'(1);
        cnt   <= cnt - CW'(1);
      end
    end
  end

endmodule
